// File: rtl/stream_fb_writer_if.sv
// Pixel stream in, frame-buffer write port out, bundled for the frame-buffer writer.
// master drives the stream and observes writes; slave is the writer itself.
interface stream_fb_writer_if #(
  parameter int ADDR_W = 17
);
  logic [31:0]       tdata;
  logic              tvalid;
  logic              fsync;
  logic              tlast;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output tdata, tvalid, fsync, tlast,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  tdata, tvalid, fsync, tlast,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/stream_fb_writer.sv
// Captures one source frame per fsync into the RGB444 frame buffer, with optional 2x2 decimation.
// Tracks beat/line position, realigns each line to its own base address and flags malformed lines/frames.
module stream_fb_writer #(
  parameter int H_SRC    = 640,
  parameter int V_SRC    = 480,
  parameter int DECIMATE = 1,
  parameter int ADDR_W   = 17
) (
  input  logic                clk25,
  input  logic                resetn,
  stream_fb_writer_if.slave   bus,
  output logic                busy,
  output logic                frame_done,
  output logic                line_err,
  output logic                frame_err,
  output logic [7:0]          frame_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [9:0]        H_LIM     = 10'(H_SRC);
  localparam logic [9:0]        H_LAST    = 10'(H_SRC - 1);
  localparam logic [9:0]        V_LAST    = 10'(V_SRC - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_SRC >> DECIMATE);
  localparam bit                DEC_ON    = (DECIMATE != 0);

  state_t            state;
  logic [9:0]        x, y;
  logic [ADDR_W-1:0] line_base;

  logic              final_beat, restart, beat, keep;
  logic [9:0]        xe, ye;
  logic [ADDR_W-1:0] be;
  logic              unused_tdata;

  assign unused_tdata = ^{bus.tdata[31:24], bus.tdata[19:16], bus.tdata[11:8], bus.tdata[3:0]};
  assign busy = (state == ACTIVE);

  // A restart presents the coincident beat as pixel (0,0) of the new frame,
  // except when the same beat closes the previous frame.
  always_comb begin
    final_beat = (state == ACTIVE) & bus.tvalid & bus.tlast & (y == V_LAST);
    restart    = bus.fsync & ~final_beat;
    xe         = restart ? 10'd0 : x;
    ye         = restart ? 10'd0 : y;
    be         = restart ? '0 : line_base;
    beat       = bus.tvalid & (restart | (state == ACTIVE));
    keep       = beat & (xe < H_LIM) & (~DEC_ON | (~xe[0] & ~ye[0]));
  end

  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      line_base   <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      bus.wr_en  <= keep;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      if (keep) begin
        bus.wr_addr <= be + ADDR_W'(xe >> DECIMATE);
        bus.wr_data <= {4'b0, bus.tdata[23:20], bus.tdata[15:12], bus.tdata[7:4]};
      end

      if (restart) begin
        frame_err <= (state == ACTIVE);
        state     <= ACTIVE;
        x         <= (bus.tvalid && H_SRC > 0) ? 10'd1 : 10'd0;
        y         <= '0;
        line_base <= '0;
      end else if (beat) begin
        if (bus.tlast) begin
          line_err <= (x != H_LAST);
          x        <= '0;
          y        <= y + 10'd1;
          if (!DEC_ON || !y[0])
            line_base <= line_base + LINE_STEP;
          if (final_beat) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            if (bus.fsync) begin
              y         <= '0;
              line_base <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end else if (x < H_LIM) begin
          x <= x + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_fb_writer.sv
// Randomized bench for stream_fb_writer on a reduced 16x8 source frame with 2x2 decimation.
// Expected writes and status pulses come from a frame/row/column model of the capture rules.
module tb_stream_fb_writer;

  localparam int H   = 16;
  localparam int V   = 8;
  localparam int DEC = 1;
  localparam int AW  = 17;

  logic       clk25 = 1'b0;
  logic       resetn = 1'b0;
  logic       busy, frame_done, line_err, frame_err;
  logic [7:0] frame_count;

  always #20 clk25 = ~clk25;

  stream_fb_writer_if #(.ADDR_W(AW)) bus ();

  stream_fb_writer #(
    .H_SRC(H), .V_SRC(V), .DECIMATE(DEC), .ADDR_W(AW)
  ) dut (
    .clk25      (clk25),
    .resetn     (resetn),
    .bus        (bus.slave),
    .busy       (busy),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_wr = 0, n_done = 0;

  // reference model state
  bit m_act;
  int row, col, m_cnt;
  bit e_we, e_busy, e_done, e_lerr, e_ferr;
  int e_addr, e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int base_of(input int r);
    return DEC ? ((r + 1) / 2) * (H / 2) : r * H;
  endfunction

  function automatic bit kept(input int c, input int r);
    return (c < H) && (DEC == 0 || (c % 2 == 0 && r % 2 == 0));
  endfunction

  task automatic emit(input int c, input int r, input logic [31:0] td);
    e_we   = 1'b1;
    e_addr = base_of(r) + (DEC ? c / 2 : c);
    e_data = {16'b0, 4'b0, td[23:20], td[15:12], td[7:4]};
  endtask

  task automatic model_reset();
    m_act = 0; row = 0; col = 0; m_cnt = 0;
    e_we = 0; e_busy = 0; e_done = 0; e_lerr = 0; e_ferr = 0;
    e_addr = 0; e_data = 0;
  endtask

  task automatic model_step(input bit fs, input bit tv, input bit tl, input logic [31:0] td);
    bit fin;
    e_we = 0; e_done = 0; e_lerr = 0; e_ferr = 0;
    fin = m_act && tv && tl && (row == V - 1);
    if (fs && !fin) begin
      if (m_act) e_ferr = 1;
      m_act = 1; row = 0; col = 0;
      if (tv) begin
        emit(0, 0, td);
        col = 1;
      end
    end else if (m_act && tv) begin
      if (kept(col, row)) emit(col, row, td);
      if (tl) begin
        if (col != H - 1) e_lerr = 1;
        row++;
        col = 0;
        if (fin) begin
          e_done = 1;
          m_cnt  = (m_cnt + 1) % 256;
          if (fs) row = 0;
          else    m_act = 0;
        end
      end else begin
        col++;
      end
    end
    e_busy = m_act;
  endtask

  task automatic cyc(input bit rst, input bit fs, input bit tv, input bit tl);
    logic [31:0] td;
    td = $urandom;
    @(negedge clk25);
    chk("wr_en", bus.wr_en, e_we);
    chk("wr_addr", bus.wr_addr, e_addr);
    chk("wr_data", bus.wr_data, e_data);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_done);
    chk("line_err", line_err, e_lerr);
    chk("frame_err", frame_err, e_ferr);
    chk("frame_count", frame_count, m_cnt);
    if (bus.wr_en === 1'b1) n_wr++;
    if (frame_done === 1'b1) n_done++;
    if (rst) begin
      resetn = 1'b0;
      model_reset();
    end else begin
      resetn = 1'b1;
      model_step(fs, tv, tl, td);
    end
    bus.fsync  = fs;
    bus.tvalid = tv;
    bus.tlast  = tl;
    bus.tdata  = td;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)));
  endtask

  // one line of len beats, tlast on the last, random idle gaps; optional fsync on the last beat
  task automatic line(input int len, input bit fs_last);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      cyc(0, fs_last && (i == len - 1), 1, i == len - 1);
    end
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(H, 0);
  endtask

  initial begin
    int w0, d0;
    bus.tdata = '0; bus.tvalid = 0; bus.fsync = 0; bus.tlast = 0;
    model_reset();

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("reset busy", busy, 0);

    // beats with no fsync are ignored
    w0 = n_wr;
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1'($urandom_range(0, 1)));
    idle(2);
    chk("idle writes", n_wr - w0, 0);

    // clean frame
    w0 = n_wr; d0 = n_done;
    cyc(0, 1, 0, 0);
    lines(V);
    idle(3);
    chk("frame writes", n_wr - w0, (H / 2) * (V / 2));
    chk("frame done once", n_done - d0, 1);
    chk("frame count 1", frame_count, 1);

    // early tlast on line 2
    cyc(0, 1, 0, 0);
    line(H, 0); line(H, 0); line(11, 0); line(H - 11, 0);
    lines(V - 4);
    idle(2);
    chk("frame count 2", frame_count, 2);

    // overlong line 0
    cyc(0, 1, 0, 0);
    line(H + 5, 0);
    lines(V - 1);
    idle(2);
    chk("frame count 3", frame_count, 3);

    // mid-frame fsync with a coincident beat
    cyc(0, 1, 0, 0);
    lines(4);
    line(5, 0);
    cyc(0, 1, 1, 0);
    idle(1);
    chk("restart count held", frame_count, 3);
    line(H - 1, 0);
    lines(V - 1);
    idle(2);
    chk("frame count 4", frame_count, 4);

    // fsync coincident with the final tlast starts the next frame directly
    cyc(0, 1, 0, 0);
    lines(V - 1);
    line(H, 1);
    lines(V);
    idle(2);
    chk("frame count 6", frame_count, 6);

    // reset mid-frame, then a full frame
    cyc(0, 1, 0, 0);
    lines(3);
    line(6, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
    idle(1);
    chk("post-reset count", frame_count, 0);
    w0 = n_wr;
    cyc(0, 1, 0, 0);
    lines(V);
    idle(3);
    chk("post-reset writes", n_wr - w0, (H / 2) * (V / 2));
    chk("post-reset count 1", frame_count, 1);

    // random traffic with stray fsync, tlast and reset
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 999) < 3,
          $urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, H - 1) == 0);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
